sudoku_fsm: RTL and testbench



---
 rtl/sudoku_fsm.sv | 175 +++++++++++++++++
 tb/tb_sudoku_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_fsm.sv
// rtl/sudoku_fsm.sv - Sudoku game-control FSM with 9x9 board store and cursor
// Sequences title, difficulty, load, navigation, number entry and end screens.
module sudoku_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_button,
   input  logic       a_button,
   input  logic       b_button,
   input  logic       up_button,
   input  logic       down_button,
   input  logic       left_button,
   input  logic       right_button,
   input  logic       test_cell_count,
   input  logic       test_lose,
   output logic [2:0] current_state,
   output logic       title_display,
   output logic       difficulty_display,
   output logic       running_display,
   output logic       easy_selected,
   output logic       hard_selected,
   output logic [3:0] cursor_x,
   output logic [3:0] cursor_y
);

   typedef enum logic [2:0] {
      INICIAR       = 3'd0,
      SELEC_DIF     = 3'd1,
      CARREGANDO    = 3'd2,
      CORRENDO_MAPA = 3'd3,
      PERCORRER_NUM = 3'd4,
      VITORIA       = 3'd5,
      DERROTA       = 3'd6,
      NAO_USADO     = 3'd7
   } state_t;

   localparam int B_START = 0;
   localparam int B_A     = 1;
   localparam int B_B     = 2;
   localparam int B_UP    = 3;
   localparam int B_DOWN  = 4;
   localparam int B_LEFT  = 5;
   localparam int B_RIGHT = 6;

   state_t     r_state, w_state_next;
   logic [6:0] r_btn_q;
   logic [6:0] w_btn_raw;
   logic [6:0] w_press;

   // Board indexed column then row; name kept for hierarchical access.
   logic [3:0] cell_value [0:8][0:8];

   logic [3:0] r_candidate, w_candidate_next;
   logic [6:0] r_filled, w_filled_next;
   logic [3:0] r_cx, w_cx_next;
   logic [3:0] r_cy, w_cy_next;
   logic       r_hard, w_hard_next;
   logic       w_clear;
   logic       w_write;
   logic [3:0] w_cell_cur;

   assign w_btn_raw  = {right_button, left_button, down_button, up_button,
                        b_button, a_button, start_button};
   assign w_press    = w_btn_raw & ~r_btn_q;
   assign w_cell_cur = cell_value[r_cx][r_cy];

   always_comb begin
      w_state_next     = r_state;
      w_candidate_next = r_candidate;
      w_filled_next    = r_filled;
      w_cx_next        = r_cx;
      w_cy_next        = r_cy;
      w_hard_next      = r_hard;
      w_clear          = 1'b0;
      w_write          = 1'b0;
      case (r_state)
         INICIAR: begin
            if (w_press[B_START]) w_state_next = SELEC_DIF;
         end
         SELEC_DIF: begin
            if (w_press[B_A])         w_state_next = CARREGANDO;
            else if (w_press[B_UP])   w_hard_next  = 1'b0;
            else if (w_press[B_DOWN]) w_hard_next  = 1'b1;
         end
         CARREGANDO: begin
            w_clear          = 1'b1;
            w_candidate_next = 4'd0;
            w_filled_next    = 7'd0;
            w_cx_next        = 4'd0;
            w_cy_next        = 4'd0;
            w_state_next     = CORRENDO_MAPA;
         end
         CORRENDO_MAPA: begin
            if (w_press[B_A]) begin
               w_candidate_next = w_cell_cur;
               w_state_next     = PERCORRER_NUM;
            end
            else if (w_press[B_UP])    w_cy_next = (r_cy == 4'd0) ? 4'd8 : r_cy - 4'd1;
            else if (w_press[B_DOWN])  w_cy_next = (r_cy >= 4'd8) ? 4'd0 : r_cy + 4'd1;
            else if (w_press[B_LEFT])  w_cx_next = (r_cx == 4'd0) ? 4'd8 : r_cx - 4'd1;
            else if (w_press[B_RIGHT]) w_cx_next = (r_cx >= 4'd8) ? 4'd0 : r_cx + 4'd1;
         end
         PERCORRER_NUM: begin
            if (w_press[B_A]) begin
               w_write = 1'b1;
               if (w_cell_cur == 4'd0 && r_candidate != 4'd0)
                  w_filled_next = r_filled + 7'd1;
               else if (w_cell_cur != 4'd0 && r_candidate == 4'd0)
                  w_filled_next = r_filled - 7'd1;
               // Lose overrides win when both hooks are high.
               if (test_lose)
                  w_state_next = DERROTA;
               else if (test_cell_count || w_filled_next == 7'd81)
                  w_state_next = VITORIA;
               else
                  w_state_next = CORRENDO_MAPA;
            end
            else if (w_press[B_B]) begin
               w_candidate_next = 4'd0;
               w_state_next     = CORRENDO_MAPA;
            end
            else if (w_press[B_UP])
               w_candidate_next = (r_candidate >= 4'd9) ? 4'd1 : r_candidate + 4'd1;
            else if (w_press[B_DOWN])
               w_candidate_next = (r_candidate <= 4'd1) ? 4'd9 : r_candidate - 4'd1;
         end
         VITORIA, DERROTA: begin
            if (w_press[B_START]) w_state_next = SELEC_DIF;
         end
         default: w_state_next = INICIAR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= INICIAR;
         r_btn_q     <= 7'd0;
         r_candidate <= 4'd0;
         r_filled    <= 7'd0;
         r_cx        <= 4'd0;
         r_cy        <= 4'd0;
         r_hard      <= 1'b0;
         for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
               cell_value[x][y] <= 4'd0;
      end
      else begin
         r_state     <= w_state_next;
         r_btn_q     <= w_btn_raw;
         r_candidate <= w_candidate_next;
         r_filled    <= w_filled_next;
         r_cx        <= w_cx_next;
         r_cy        <= w_cy_next;
         r_hard      <= w_hard_next;
         if (w_clear) begin
            for (int x = 0; x < 9; x++)
               for (int y = 0; y < 9; y++)
                  cell_value[x][y] <= 4'd0;
         end
         else if (w_write) begin
            cell_value[r_cx][r_cy] <= r_candidate;
         end
      end
   end

   assign current_state      = r_state;
   assign title_display      = (r_state == INICIAR);
   assign difficulty_display = (r_state == SELEC_DIF);
   assign running_display    = (r_state == CARREGANDO) || (r_state == CORRENDO_MAPA) ||
                               (r_state == PERCORRER_NUM);
   assign easy_selected      = ~r_hard;
   assign hard_selected      = r_hard;
   assign cursor_x           = r_cx;
   assign cursor_y           = r_cy;

endmodule

// File: tb/tb_sudoku_fsm.sv
// tb/tb_sudoku_fsm.sv - directed scoreboard bench for sudoku_fsm
// Expected values are queued before each stimulus step and popped after it.
module tb_sudoku_fsm;

   localparam int START = 0;
   localparam int A     = 1;
   localparam int B     = 2;
   localparam int UP    = 3;
   localparam int DOWN  = 4;
   localparam int LEFT  = 5;
   localparam int RIGHT = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] btn;
   logic       test_cell_count;
   logic       test_lose;
   logic [2:0] current_state;
   logic       title_display, difficulty_display, running_display;
   logic       easy_selected, hard_selected;
   logic [3:0] cursor_x, cursor_y;

   int checks   = 0;
   int failures = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   sudoku_fsm dut (
      .clk                (clk),
      .reset              (reset),
      .start_button       (btn[START]),
      .a_button           (btn[A]),
      .b_button           (btn[B]),
      .up_button          (btn[UP]),
      .down_button        (btn[DOWN]),
      .left_button        (btn[LEFT]),
      .right_button       (btn[RIGHT]),
      .test_cell_count    (test_cell_count),
      .test_lose          (test_lose),
      .current_state      (current_state),
      .title_display      (title_display),
      .difficulty_display (difficulty_display),
      .running_display    (running_display),
      .easy_selected      (easy_selected),
      .hard_selected      (hard_selected),
      .cursor_x           (cursor_x),
      .cursor_y           (cursor_y)
   );

   task automatic push(input string tag, input logic [31:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      end
      else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
         end
      end
   endtask

   task automatic press(input int idx);
      @(negedge clk);
      btn[idx] = 1'b1;
      @(negedge clk);
      btn[idx] = 1'b0;
   endtask

   task automatic press_n(input int idx, input int n);
      for (int i = 0; i < n; i++) press(idx);
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget);
      int n = 0;
      while (current_state !== tgt && n < budget) begin
         @(negedge clk);
         n++;
      end
      push("wait_state", {29'd0, tgt});
      pop_check({29'd0, current_state});
   endtask

   task automatic expect_cursor(input string tag, input int x, input int y);
      push({tag, "_x"}, x);
      push({tag, "_y"}, y);
      pop_check({28'd0, cursor_x});
      pop_check({28'd0, cursor_y});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; btn = 7'd0; test_cell_count = 1'b0; test_lose = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      push("rst_state", 0); push("rst_title", 1); push("rst_running", 0);
      push("rst_easy", 1); push("rst_hard", 0);
      pop_check(current_state); pop_check(title_display); pop_check(running_display);
      pop_check(easy_selected); pop_check(hard_selected);
      expect_cursor("rst_cur", 0, 0);

      push("start_to_sel", 1); push("diff_disp", 1);
      press(START);
      pop_check(current_state); pop_check(difficulty_display);

      push("hard_sel", 1); push("easy_clr", 0);
      press(DOWN);
      pop_check(hard_selected); pop_check(easy_selected);

      push("load_state", 2);
      press(A);
      pop_check(current_state);
      push("map_state", 3); push("running", 1);
      @(negedge clk);
      pop_check(current_state); pop_check(running_display);
      expect_cursor("load_cur", 0, 0);

      // Held button must act only once.
      @(negedge clk); btn[RIGHT] = 1'b1;
      repeat (3) @(negedge clk);
      btn[RIGHT] = 1'b0;
      expect_cursor("held_right", 1, 0);
      press(LEFT);
      expect_cursor("back_left", 0, 0);

      press(UP);    expect_cursor("wrap_up", 0, 8);
      press(LEFT);  expect_cursor("wrap_left", 8, 8);
      press(DOWN);  expect_cursor("wrap_down", 8, 0);
      press(RIGHT); expect_cursor("wrap_right", 0, 0);

      push("entry_state", 4);
      press(A);
      pop_check(current_state);
      press_n(UP, 4);
      push("commit_state", 3); push("cell00", 4); push("filled1", 1);
      press(A);
      pop_check(current_state); pop_check(dut.cell_value[0][0]); pop_check(dut.r_filled);

      press(LEFT);
      press(A);
      press_n(UP, 11);
      push("cell80_wrap", 2); push("commit2_state", 3);
      press(A);
      pop_check(dut.cell_value[8][0]); pop_check(current_state);

      press(A);
      press_n(UP, 5);
      push("cancel_state", 3); push("cancel_cell", 2);
      press(B);
      pop_check(current_state); pop_check(dut.cell_value[8][0]);

      press(A);
      test_cell_count = 1'b1;
      push("win_state", 5);
      press(A);
      test_cell_count = 1'b0;
      pop_check(current_state);
      push("win_restart", 1);
      press(START);
      pop_check(current_state);

      press(A);
      wait_state(3'd3, 10);
      push("reload_cell", 0); push("reload_filled", 0);
      pop_check(dut.cell_value[8][0]); pop_check(dut.r_filled);
      press(A);
      test_lose = 1'b1;
      push("lose_state", 6);
      press(A);
      test_lose = 1'b0;
      pop_check(current_state);
      push("lose_restart", 1);
      press(START);
      pop_check(current_state);

      press(A);
      wait_state(3'd3, 10);
      press(A);
      push("cand_dn0", 9);  press(DOWN); pop_check(dut.r_candidate);
      push("cand_dn9", 8);  press(DOWN); pop_check(dut.r_candidate);
      press(UP);
      push("cand_up9", 1);  press(UP);   pop_check(dut.r_candidate);
      test_lose = 1'b1; test_cell_count = 1'b1;
      push("both_state", 6); push("both_cell", 1);
      press(A);
      test_lose = 1'b0; test_cell_count = 1'b0;
      pop_check(current_state); pop_check(dut.cell_value[0][0]);
      press(START);

      press(A);
      wait_state(3'd3, 10);
      press(RIGHT);
      press(A);
      press(UP);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      push("midreset_state", 0); push("midreset_cand", 0); push("midreset_easy", 1);
      pop_check(current_state); pop_check(dut.r_candidate); pop_check(easy_selected);
      expect_cursor("midreset_cur", 0, 0);
      @(negedge clk);
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
